// File: rtl/i2c_pkg.sv
// Shared FSM encoding, default limits and width helpers for the I2C request arbiter.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_NREQ      = 3;
  localparam int DEF_MAX_RETRY = 2;
  localparam int DEF_TIMEOUT   = 63;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/i2c_arb_if.sv
// Requester and PHY signal bundle of the arbiter; slave is the arbiter side.
interface i2c_arb_if import i2c_pkg::*; #(parameter int NREQ = DEF_NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [8*NREQ-1:0]  req_addr;
  logic [16*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    done;
  logic               rsp_ack;
  logic               rsp_tmo;
  logic [15:0]        rsp_rdata;
  logic               busy;
  logic               phy_go;
  logic               phy_wr;
  logic [7:0]         phy_addr;
  logic [15:0]        phy_wdata;
  logic               phy_finish;
  logic               phy_ack;
  logic [15:0]        phy_rdata;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, phy_finish, phy_ack, phy_rdata,
    output done, rsp_ack, rsp_tmo, rsp_rdata, busy, phy_go, phy_wr, phy_addr, phy_wdata
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, phy_finish, phy_ack, phy_rdata,
    input  done, rsp_ack, rsp_tmo, rsp_rdata, busy, phy_go, phy_wr, phy_addr, phy_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from ptr+1 modulo NREQ.
module rr_pick import i2c_pkg::*; #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Scan farthest-first so the candidate nearest ptr+1 is the last one written.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      w_cand = w_sum[IW-1:0];
      if (req[w_cand]) begin
        valid = 1'b1;
        index = w_cand;
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin arbiter sharing one I2C PHY; retries NACKed transfers and aborts stalled ones.
// states: IDLE pick | ISSUE raise go | WAIT finish/timeout | GAP go low 1 cycle | DONE pulse done
module i2c_arb import i2c_pkg::*; #(
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic      clk,
  input logic      rst,
  i2c_arb_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int TW = cnt_w(TIMEOUT);

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_ptr, r_idx, w_pick;
  logic          w_valid;
  logic          r_wr;
  logic [7:0]    r_addr;
  logic [15:0]   r_wdata;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tmo_cnt, w_tmo_nx;
  logic          r_ack, r_tmo;
  logic [15:0]   r_rdata;
  logic          w_retry_max, w_tmo_hit, w_in_done;
  logic [7:0]    w_pick_addr;
  logic [15:0]   w_pick_wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .index (w_pick)
  );

  assign w_pick_addr  = 8'(bus.req_addr >> {w_pick, 3'b000});
  assign w_pick_wdata = 16'(bus.req_wdata >> {w_pick, 4'b0000});
  assign w_retry_max  = (r_retry == RW'(MAX_RETRY));
  assign w_tmo_nx     = (r_tmo_cnt == TW'(TIMEOUT)) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
  assign w_tmo_hit    = (w_tmo_nx == TW'(TIMEOUT));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_valid) w_state_nx = S_ISSUE;
      S_ISSUE: w_state_nx = S_WAIT;
      // A finish on the same cycle as the timeout limit wins over the timeout.
      S_WAIT: begin
        if (bus.phy_finish) begin
          w_state_nx = (bus.phy_ack || w_retry_max) ? S_DONE : S_GAP;
        end else if (w_tmo_hit) begin
          w_state_nx = S_DONE;
        end
      end
      S_GAP:   w_state_nx = S_ISSUE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= IW'(NREQ - 1);
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_retry   <= '0;
      r_tmo_cnt <= '0;
      r_ack     <= 1'b0;
      r_tmo     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_idx     <= w_pick;
            r_wr      <= bus.req_wr[w_pick];
            r_addr    <= w_pick_addr;
            r_wdata   <= w_pick_wdata;
            r_retry   <= '0;
            r_tmo_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (bus.phy_finish) begin
            if (bus.phy_ack || w_retry_max) begin
              r_ack   <= bus.phy_ack;
              r_tmo   <= 1'b0;
              r_rdata <= bus.phy_rdata;
            end else begin
              r_retry   <= r_retry + RW'(1);
              r_tmo_cnt <= '0;
            end
          end else begin
            r_tmo_cnt <= w_tmo_nx;
            if (w_tmo_hit) begin
              r_ack   <= 1'b0;
              r_tmo   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        S_DONE:  r_ptr <= r_idx;
        default: ;
      endcase
    end
  end

  assign w_in_done     = (r_state == S_DONE);
  assign bus.phy_go    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.phy_wr    = r_wr;
  assign bus.phy_addr  = r_addr;
  assign bus.phy_wdata = r_wdata;
  assign bus.done      = w_in_done ? (NREQ'(1) << r_idx) : '0;
  assign bus.rsp_ack   = w_in_done & r_ack;
  assign bus.rsp_tmo   = w_in_done & r_tmo;
  assign bus.rsp_rdata = w_in_done ? r_rdata : '0;

endmodule
